// File: rtl/rs_syndrome_stage_if.sv
// ---------------------------------------------------------------------------
// rs_syndrome_stage_if
//   Codeword-in / syndrome-out handshake bundle for the RS syndrome stage.
//   Signal names are seen from the syndrome stage: i_* are driven towards it,
//   o_* are driven by it.
//
//   i_start_codeword  first symbol of a codeword (highest-degree coefficient)
//   i_end_codeword    last symbol of a codeword (r_0)
//   i_valid           i_symbol and flags valid this cycle
//   i_symbol          received symbol, WORD_LENGTH bits
//   i_consume         downstream takes the syndrome this cycle
//   o_in_ready        stage accepts a symbol this cycle
//   o_valid           o_syndrome / o_has_error valid
//   o_syndrome        packed S_1..S_{N-K}, S_1 in the LSBs
//   o_has_error       any syndrome nonzero
//   o_error           sticky framing error
//
//   master: upstream source + downstream sink (testbench side)
//   slave : the syndrome stage itself
// ---------------------------------------------------------------------------
interface rs_syndrome_stage_if #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned N           = 15,
  parameter int unsigned K           = 11
);

  logic                          i_start_codeword;
  logic                          i_end_codeword;
  logic                          i_valid;
  logic [WORD_LENGTH-1:0]        i_symbol;
  logic                          i_consume;
  logic                          o_in_ready;
  logic                          o_valid;
  logic [(N-K)*WORD_LENGTH-1:0]  o_syndrome;
  logic                          o_has_error;
  logic                          o_error;

  modport master (
    output i_start_codeword, i_end_codeword, i_valid, i_symbol, i_consume,
    input  o_in_ready, o_valid, o_syndrome, o_has_error, o_error
  );

  modport slave (
    input  i_start_codeword, i_end_codeword, i_valid, i_symbol, i_consume,
    output o_in_ready, o_valid, o_syndrome, o_has_error, o_error
  );

endinterface

// File: rtl/rs_syndrome_stage.sv
// ---------------------------------------------------------------------------
// rs_syndrome_stage
//   First stage of the RS decoder. Consumes one N-symbol codeword (highest
//   degree first) and evaluates the received polynomial at alpha^1..alpha^(N-K)
//   with one Horner step per accepted symbol:
//     Acc_j <= Acc_j * alpha^j ^ r
//   After the end symbol the syndromes are held on o_syndrome with o_valid
//   until the downstream consumes them; a new codeword may start in the same
//   cycle as the consume.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     s     rs_syndrome_stage_if.slave (symbol input + syndrome output)
// ---------------------------------------------------------------------------
module rs_syndrome_stage #(
  parameter int unsigned          WORD_LENGTH = 8,
  parameter int unsigned          N           = 15,
  parameter int unsigned          K           = 11,
  parameter logic [WORD_LENGTH:0] PRIM_POLY   = 9'h11D
) (
  input logic                clk,
  input logic                rst,
  rs_syndrome_stage_if.slave s
);

  localparam int unsigned        NUM_SYN  = N - K;
  localparam int unsigned        CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(N - 1);

  typedef logic [NUM_SYN-1:0][WORD_LENGTH-1:0] syn_t;

  typedef enum logic [1:0] {
    WAIT_SYMBOL,
    PROCESS_SYMBOLS,
    HOLD_RESULT,
    ERROR
  } state_t;

  // Multiply by alpha: shift left, fold the overflow bit back with the
  // primitive polynomial (the x^m term is implicit).
  function automatic logic [WORD_LENGTH-1:0] gf_xtime(input logic [WORD_LENGTH-1:0] x);
    gf_xtime = {x[WORD_LENGTH-2:0], 1'b0} ^ (x[WORD_LENGTH-1] ? PRIM_POLY[WORD_LENGTH-1:0] : '0);
  endfunction

  // Multiply by the constant alpha^pwr. pwr is a generate constant at every
  // call site, so this unrolls to a fixed XOR network.
  function automatic logic [WORD_LENGTH-1:0] gf_mul_alpha_pow(input logic [WORD_LENGTH-1:0] x,
                                                             input int unsigned pwr);
    logic [WORD_LENGTH-1:0] y;
    y = x;
    for (int unsigned i = 0; i < NUM_SYN; i++) begin
      if (i < pwr) y = gf_xtime(y);
    end
    return y;
  endfunction

  state_t           r_state;
  syn_t             r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  syn_t             r_syndrome;
  logic             r_has_error;
  logic             r_error;

  logic             w_in_ready;
  logic             w_accept;
  syn_t             w_acc_step;
  syn_t             w_acc_load;

  // Lane j-1 holds S_j, so it multiplies by alpha^j.
  for (genvar j = 0; j < NUM_SYN; j++) begin : g_horner
    assign w_acc_step[j] = gf_mul_alpha_pow(r_acc[j], j + 1) ^ s.i_symbol;
    assign w_acc_load[j] = s.i_symbol;
  end

  // NOTE: every output of an always_comb gets a default before the case,
  // otherwise an uncovered path holds its old value and infers a latch.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      WAIT_SYMBOL,
      PROCESS_SYMBOLS: w_in_ready = 1'b1;
      HOLD_RESULT:     w_in_ready = s.i_consume;
      default:         w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = s.i_valid && w_in_ready;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT_SYMBOL;
      // NOTE: the accumulators are a handful of flops, not a RAM, so they
      // take the reset like every other register.
      r_acc       <= '0;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_syndrome  <= '0;
      r_has_error <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        // Idle and result-holding share the "new codeword" path; in
        // HOLD_RESULT w_accept already implies i_consume.
        WAIT_SYMBOL,
        HOLD_RESULT: begin
          if (w_accept) begin
            r_valid     <= 1'b0;
            r_syndrome  <= '0;
            r_has_error <= 1'b0;
            if (!s.i_start_codeword) begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end else begin
              r_acc <= w_acc_load;
              r_cnt <= CNT_W'(1);
              if (s.i_end_codeword) begin
                // A one-symbol codeword only exists when N == 1.
                if (N == 1) begin
                  r_state     <= HOLD_RESULT;
                  r_valid     <= 1'b1;
                  r_syndrome  <= w_acc_load;
                  r_has_error <= |w_acc_load;
                end else begin
                  r_state <= ERROR;
                  r_error <= 1'b1;
                end
              end else begin
                r_state <= PROCESS_SYMBOLS;
              end
            end
          end else if (r_state == HOLD_RESULT && s.i_consume) begin
            r_state     <= WAIT_SYMBOL;
            r_valid     <= 1'b0;
            r_syndrome  <= '0;
            r_has_error <= 1'b0;
          end
        end

        PROCESS_SYMBOLS: begin
          if (w_accept) begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + CNT_W'(1);
            // End must coincide exactly with the N-th symbol; a second
            // start inside the codeword is also a framing fault.
            if (s.i_start_codeword || (s.i_end_codeword != (r_cnt == LAST_CNT))) begin
              r_state <= ERROR;
              r_error <= 1'b1;
            end else if (s.i_end_codeword) begin
              r_state     <= HOLD_RESULT;
              r_valid     <= 1'b1;
              r_syndrome  <= w_acc_step;
              r_has_error <= |w_acc_step;
            end
          end
        end

        default: begin
          // ERROR is sticky until reset.
          r_valid     <= 1'b0;
          r_syndrome  <= '0;
          r_has_error <= 1'b0;
          r_error     <= 1'b1;
        end
      endcase
    end
  end

  assign s.o_in_ready  = w_in_ready;
  assign s.o_valid     = r_valid;
  assign s.o_syndrome  = r_syndrome;
  assign s.o_has_error = r_has_error;
  assign s.o_error     = r_error;

endmodule
